// File: rtl/rf_wb_arbiter_if.sv
// Port bundle between the register-file write arbiter and its pipeline/decode neighbours.
// Handshake: a source-B result transfers on a rising edge where b_valid && b_ready; b_ready never depends on b_valid.
interface rf_wb_arbiter_if;
  logic        a_valid;
  logic [4:0]  a_dest;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_dest;
  logic [31:0] b_data;
  logic        iss_valid;
  logic [4:0]  iss_dest;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        hazard;
  logic        wb_hold;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  modport master (
    output a_valid, a_dest, a_data, b_valid, b_dest, b_data,
    output iss_valid, iss_dest, rs1, rs2,
    input  b_ready, hazard, wb_hold, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  a_valid, a_dest, a_data, b_valid, b_dest, b_data,
    input  iss_valid, iss_dest, rs1, rs2,
    output b_ready, hazard, wb_hold, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Merges pipeline writeback (A, always first) and a FIFO of long-latency results (B) onto the
// single register-file write port, and tracks registers still owed by B for decode hazards.
module rf_wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic            clk,
  input  logic            reset,
  rf_wb_arbiter_if.slave  bus
);
  localparam int            PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW         = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [7:0]    STARVE_LIM = 8'(STARVE_MAX);

  logic [4:0]    dest_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    starve_q, starve_d;
  logic          hold_q, hold_d;
  logic          rf_we_q, rf_we_d;
  logic          from_b_q, from_b_d;
  logic [4:0]    rf_waddr_q, rf_waddr_d;
  logic [31:0]   rf_wdata_q, rf_wdata_d;
  logic [31:0]   pend_q, pend_d;
  logic          full, empty, push, pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign push  = bus.b_valid && !full;
  assign pop   = !bus.a_valid && !empty;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Dest 0 still goes through the write register so a popped r0 result is consumed.
  always_comb begin
    rf_we_d    = 1'b0;
    from_b_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (bus.a_valid) begin
      rf_we_d    = (bus.a_dest != 5'd0);
      rf_waddr_d = bus.a_dest;
      rf_wdata_d = bus.a_data;
    end else if (pop) begin
      rf_we_d    = (dest_mem[rd_ptr_q] != 5'd0);
      from_b_d   = 1'b1;
      rf_waddr_d = dest_mem[rd_ptr_q];
      rf_wdata_d = data_mem[rd_ptr_q];
    end
  end

  // Clear happens after the write is in the register file; a same-edge issue re-sets the bit.
  always_comb begin
    pend_d = pend_q;
    if (from_b_q && rf_we_q) pend_d[rf_waddr_q] = 1'b0;
    if (bus.iss_valid && (bus.iss_dest != 5'd0)) pend_d[bus.iss_dest] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_comb begin
    if (pop || empty)              starve_d = '0;
    else if (starve_q < STARVE_LIM) starve_d = starve_q + 8'd1;
    else                           starve_d = starve_q;
    hold_d = pop ? 1'b0 : (hold_q | (starve_d == STARVE_LIM));
  end

  always_ff @(posedge clk) begin
    if (push) begin
      dest_mem[wr_ptr_q] <= bus.b_dest;
      data_mem[wr_ptr_q] <= bus.b_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      hold_q     <= 1'b0;
      rf_we_q    <= 1'b0;
      from_b_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      pend_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      hold_q     <= hold_d;
      rf_we_q    <= rf_we_d;
      from_b_q   <= from_b_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      pend_q     <= pend_d;
    end
  end

  assign bus.b_ready  = !full;
  assign bus.hazard   = pend_q[bus.rs1] | pend_q[bus.rs2] | (bus.iss_valid & pend_q[bus.iss_dest]);
  assign bus.wb_hold  = hold_q;
  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_rf_wb_arbiter;
  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
  } b_ent_t;

  logic clk;
  logic reset;
  rf_wb_arbiter_if bus ();

  rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  b_ent_t      fifo_m [$];
  logic [36:0] exp_q  [$];
  logic [31:0] m_pend;
  int          m_starve;
  logic        m_hold;
  logic        m_we, m_b;
  logic [4:0]  m_addr;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.a_valid = 1'b0; bus.a_dest = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_dest = '0; bus.b_data = '0;
    bus.iss_valid = 1'b0; bus.iss_dest = '0; bus.rs1 = '0; bus.rs2 = '0;
  endtask

  // Model: one step of the arbiter rules per rising edge, using the inputs of the ending cycle.
  int     sz;
  logic   pp, n_we, n_b;
  logic [4:0]  n_addr;
  logic [31:0] n_data;
  b_ent_t ent;
  initial begin
    m_pend = '0; m_starve = 0; m_hold = 1'b0; m_we = 1'b0; m_b = 1'b0; m_addr = '0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        fifo_m.delete(); exp_q.delete();
        m_pend = '0; m_starve = 0; m_hold = 1'b0; m_we = 1'b0; m_b = 1'b0; m_addr = '0;
      end else begin
        sz = fifo_m.size();
        pp = !bus.a_valid && (sz > 0);
        if (m_we && m_b) m_pend[m_addr] = 1'b0;
        if (bus.iss_valid && bus.iss_dest != 5'd0) m_pend[bus.iss_dest] = 1'b1;
        n_we = 1'b0; n_b = 1'b0; n_addr = '0; n_data = '0;
        if (bus.a_valid) begin
          n_we = (bus.a_dest != 5'd0); n_addr = bus.a_dest; n_data = bus.a_data;
        end else if (pp) begin
          ent = fifo_m.pop_front();
          n_we = (ent.dest != 5'd0); n_addr = ent.dest; n_data = ent.data; n_b = 1'b1;
        end
        if (bus.b_valid && sz < DEPTH) begin
          ent.dest = bus.b_dest; ent.data = bus.b_data;
          fifo_m.push_back(ent);
        end
        if (pp) begin
          m_starve = 0; m_hold = 1'b0;
        end else if (sz > 0) begin
          if (m_starve < STARVE_MAX) m_starve++;
          if (m_starve == STARVE_MAX) m_hold = 1'b1;
        end else begin
          m_starve = 0;
        end
        m_we = n_we; m_b = n_b; m_addr = n_addr;
        if (n_we) exp_q.push_back({n_addr, n_data});
      end
    end
  end

  // Monitor: compares DUT outputs with the model on every falling edge.
  logic        exp_we;
  logic [36:0] exp_w;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        exp_we = (exp_q.size() != 0);
        check("rf_we", bus.rf_we, exp_we);
        if (exp_we) begin
          exp_w = exp_q.pop_front();
          if (bus.rf_we) check("rf_write", {bus.rf_waddr, bus.rf_wdata}, exp_w);
        end
        check("b_ready", bus.b_ready, fifo_m.size() < DEPTH);
        check("wb_hold", bus.wb_hold, m_hold);
        check("hazard", bus.hazard,
              m_pend[bus.rs1] | m_pend[bus.rs2] | (bus.iss_valid & m_pend[bus.iss_dest]));
      end
    end
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  int we_seen;
  initial begin
    reset = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("reset_rf_we", bus.rf_we, 1'b0);
    check("reset_wb_hold", bus.wb_hold, 1'b0);
    check("reset_b_ready", bus.b_ready, 1'b1);
    check("reset_hazard", bus.hazard, 1'b0);
    reset = 1'b0;

    // A pass-through
    cyc();
    bus.a_valid = 1'b1; bus.a_dest = 5'd3; bus.a_data = 32'hDEADBEEF;
    cyc();
    check("a_we", bus.rf_we, 1'b1);
    check("a_waddr", bus.rf_waddr, 5'd3);
    check("a_wdata", bus.rf_wdata, 32'hDEADBEEF);
    bus.a_dest = 5'd0; bus.a_data = 32'h1;
    cyc();
    check("a_r0_we", bus.rf_we, 1'b0);
    idle();

    // Scoreboard round trip
    cyc();
    bus.iss_valid = 1'b1; bus.iss_dest = 5'd7;
    cyc();
    bus.iss_valid = 1'b0; bus.rs2 = 5'd7; #1;
    check("sb_hazard_set", bus.hazard, 1'b1);
    cyc(); cyc();
    cyc();
    bus.b_valid = 1'b1; bus.b_dest = 5'd7; bus.b_data = 32'h12345678; #1;
    check("sb_b_ready", bus.b_ready, 1'b1);
    cyc();
    bus.b_valid = 1'b0;
    check("sb_no_we_yet", bus.rf_we, 1'b0);
    cyc();
    check("sb_we", bus.rf_we, 1'b1);
    check("sb_waddr", bus.rf_waddr, 5'd7);
    check("sb_wdata", bus.rf_wdata, 32'h12345678);
    check("sb_hazard_still", bus.hazard, 1'b1);
    cyc();
    check("sb_hazard_clear", bus.hazard, 1'b0);
    idle();

    // Priority, back-pressure and starvation
    cyc();
    bus.a_valid = 1'b1; bus.a_dest = 5'd1; bus.a_data = 32'hA1;
    bus.b_valid = 1'b1; bus.b_dest = 5'd10; bus.b_data = 32'hB10;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check("prio_a_waddr", bus.rf_waddr, 5'(k));
      bus.a_dest = 5'(k + 1); bus.a_data = 32'hA1 + 32'(k);
      if (k == 1) begin bus.b_dest = 5'd11; bus.b_data = 32'hB11; end
      if (k == 2) begin
        bus.b_dest = 5'd12; bus.b_data = 32'hB12; #1;
        check("prio_b_ready_full", bus.b_ready, 1'b0);
      end
      if (k == 4) check("starve_hold_low", bus.wb_hold, 1'b0);
    end
    cyc();
    check("starve_hold_high", bus.wb_hold, 1'b1);
    check("prio_a_last", bus.rf_waddr, 5'd5);
    bus.a_valid = 1'b0;
    cyc();
    check("starve_pop_waddr", bus.rf_waddr, 5'd10);
    check("starve_pop_wdata", bus.rf_wdata, 32'hB10);
    check("starve_hold_drop", bus.wb_hold, 1'b0);
    bus.a_valid = 1'b1; bus.a_dest = 5'd6; #1;
    check("starve_b_ready", bus.b_ready, 1'b1);
    cyc();
    bus.b_valid = 1'b0; bus.a_valid = 1'b0;
    repeat (4) cyc();
    idle();

    // Same-edge set/clear on reg 9, and r0 handling
    bus.iss_valid = 1'b1; bus.iss_dest = 5'd9;
    cyc();
    bus.iss_valid = 1'b0;
    bus.b_valid = 1'b1; bus.b_dest = 5'd9; bus.b_data = 32'h99;
    cyc();
    bus.b_valid = 1'b0;
    cyc();
    check("se_we", bus.rf_we, 1'b1);
    bus.iss_valid = 1'b1; bus.iss_dest = 5'd9;
    cyc();
    bus.iss_valid = 1'b0; bus.rs1 = 5'd9; #1;
    check("se_set_wins", bus.hazard, 1'b1);
    bus.b_valid = 1'b1; bus.b_dest = 5'd9; bus.b_data = 32'h999;
    cyc();
    bus.b_valid = 1'b0;
    cyc(); cyc();
    check("se_final_clear", bus.hazard, 1'b0);
    bus.rs1 = 5'd0; bus.iss_valid = 1'b1; bus.iss_dest = 5'd0; #1;
    check("r0_iss_hazard", bus.hazard, 1'b0);
    cyc();
    bus.iss_valid = 1'b0; #1;
    check("r0_iss_after", bus.hazard, 1'b0);
    bus.b_valid = 1'b1; bus.b_dest = 5'd0; bus.b_data = 32'hAB;
    cyc();
    bus.b_valid = 1'b0;
    cyc();
    check("r0_b_we", bus.rf_we, 1'b0);
    check("r0_b_popped", bus.b_ready, 1'b1);
    cyc();
    idle();

    // Reset in the middle of traffic
    bus.iss_valid = 1'b1; bus.iss_dest = 5'd5;
    bus.a_valid = 1'b1; bus.a_dest = 5'd1; bus.a_data = 32'h5;
    bus.b_valid = 1'b1; bus.b_dest = 5'd20; bus.b_data = 32'h20;
    cyc();
    bus.iss_valid = 1'b0; bus.b_dest = 5'd21; bus.b_data = 32'h21;
    cyc();
    bus.b_valid = 1'b0; bus.rs1 = 5'd5;
    #2 reset = 1'b1;
    #1;
    check("mid_reset_rf_we", bus.rf_we, 1'b0);
    check("mid_reset_b_ready", bus.b_ready, 1'b1);
    check("mid_reset_hazard", bus.hazard, 1'b0);
    bus.a_valid = 1'b0;
    cyc();
    #2 reset = 1'b0;
    we_seen = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (bus.rf_we) we_seen++;
    end
    check("post_reset_no_writes", we_seen, 0);
    idle();

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      cyc();
      bus.a_valid   = ((i % 64) < 12) ? 1'b1 : ($urandom_range(0, 9) < 6);
      bus.a_dest    = 5'($urandom_range(0, 31));
      bus.a_data    = $urandom;
      bus.b_valid   = 1'($urandom_range(0, 1));
      bus.b_dest    = 5'($urandom_range(0, 31));
      bus.b_data    = $urandom;
      bus.iss_valid = ($urandom_range(0, 4) == 0);
      bus.iss_dest  = 5'($urandom_range(0, 31));
      bus.rs1       = 5'($urandom_range(0, 31));
      bus.rs2       = 5'($urandom_range(0, 31));
    end
    cyc();
    idle();
    repeat (10) cyc();
    check("drain_exp_q", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter and long-latency scoreboard for the 32x32 register file (one write port, two read ports, r0 hardwired to zero). It merges two write sources onto the single write port. Source A is the in-order pipeline writeback stage, which always has priority and is never back-pressured. Source B is the result port of the multi-cycle unit (divider, multiplier, uncached load), which uses a valid/ready handshake and a small FIFO. The block also keeps a scoreboard of destination registers that are still owed by source B and gives decode a hazard flag for them.

## Interface
Parameters:
- DEPTH, 2: source-B result FIFO entries (power of two, 2..8).
- STARVE_MAX, 8: cycles a non-empty FIFO may go ungranted before wb_hold asserts (1..255).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- a_valid  in  1  pipeline writeback request this cycle.
- a_dest  in  5  pipeline destination register.
- a_data  in  32  pipeline write data.
- b_valid  in  1  long-latency result valid.
- b_ready  out  1  FIFO can accept a result; equals !full.
- b_dest  in  5  long-latency destination register.
- b_data  in  32  long-latency result data.
- iss_valid  in  1  decode issues a long-latency op this cycle.
- iss_dest  in  5  destination of the issued op.
- rs1, rs2  in  5 each  decode source registers.
- hazard  out  1  combinational; 1 if rs1, rs2 or iss_dest is pending in the scoreboard.
- wb_hold  out  1  registered request to the pipeline to leave the next writeback slot empty.
- rf_we  out  1  register file write enable (registered).
- rf_waddr  out  5  register file write address (registered).
- rf_wdata  out  32  register file write data (registered).

## Operation
- **Grant.** One write reaches the register file per cycle. Selection:
  - If a_valid is 1, A wins.
  - Otherwise, if the FIFO is non-empty, the FIFO head is popped and wins.
  - Otherwise there is no write.
- **Output register.** The winner is registered into rf_we/rf_waddr/rf_wdata. A write to dest 0 is registered with rf_we=0, but a FIFO pop still occurs.
- **Write source flag.** An internal flag records whether the registered write came from B.
- **FIFO push.** The FIFO pushes when b_valid && b_ready.
  - Push and pop are allowed in the same cycle.
  - b_ready depends only on the registered occupancy: a full FIFO refuses a push even while it is popping.
  - Pointers wrap modulo DEPTH; occupancy is tracked as a count of 0..DEPTH.
- **Scoreboard set.** The scoreboard is 32 pending bits. iss_valid with iss_dest != 0 sets bit iss_dest.
- **Scoreboard clear.** A registered B-sourced write with rf_we=1 clears bit rf_waddr at the end of the cycle in which rf_we is high, so the register file already holds the data when hazard drops.
  - A B write to dest 0 clears nothing.
- **Set and clear on the same bit, same edge.** The set wins.
- **hazard.** hazard = pend[rs1] | pend[rs2] | (iss_valid & pend[iss_dest]). Bit 0 always reads 0. Decode must not issue while hazard is 1 (this blocks WAW).
- **Starvation counter.** The counter (8 bits) increments each cycle the FIFO is non-empty and no pop occurs. It resets to 0 on any pop or when the FIFO is empty, and saturates at STARVE_MAX.
- **wb_hold.** wb_hold is registered: it goes to 1 on the edge where the counter reaches STARVE_MAX. It goes to 0 on the edge of the next pop.
- **a_valid under hold.** If a_valid is still asserted while wb_hold=1, A still wins; nothing is dropped, only delayed.

## Timing
- **Reset (asynchronous).** While reset is high, all of the following are 0:
  - rf_we, rf_waddr, rf_wdata, wb_hold;
  - FIFO pointers and count;
  - the starvation counter;
  - all scoreboard bits.
  
  b_ready goes to 1 and hazard goes to 0. A reset in the middle of an operation discards FIFO contents and pending bits.
- **A latency.** a_valid in cycle t gives rf_we=1 in cycle t+1.
- **B latency.** Handshake in cycle t → entry visible in t+1 → earliest grant in t+1 → rf_we in t+2 → scoreboard bit clear and hazard low in t+3.
- **b_ready.** Falls in the cycle after the push that fills the FIFO. Rises in the cycle after a pop from full.
- **Starvation timing.** With A continuously valid and the FIFO non-empty from cycle t, the counter reaches STARVE_MAX at the end of cycle t+STARVE_MAX-1, and wb_hold is 1 in cycle t+STARVE_MAX.

## Test plan
- **Reset.** Assert reset mid-cycle with the FIFO holding 2 entries and pend[5]=1 → immediately rf_we=0, b_ready=1, hazard=0 with rs1=5. After release, no B writes occur.
- **A pass-through.** a_valid=1, a_dest=3, a_data=0xDEADBEEF in cycle 0 → cycle 1: rf_we=1, rf_waddr=3, rf_wdata=0xDEADBEEF. Then a_dest=0 → rf_we=0.
- **Scoreboard round trip.** iss_valid, iss_dest=7 in cycle 0 → hazard=1 for rs2=7 from cycle 1. B handshake dest 7, data 0x12345678 in cycle 4, A idle → rf_we in cycle 6 → hazard=0 in cycle 7.
- **Priority and back-pressure.** A valid every cycle and 3 B offers with DEPTH=2 → b_ready=0 after 2 pushes, the third offer stalls, and every rf write comes from A.
- **Starvation.** Continue the previous scenario with STARVE_MAX=4 → wb_hold=1 four cycles after the FIFO became non-empty. Drop a_valid for 1 cycle → the FIFO head is written the next cycle, wb_hold=0, and the counter restarts.
- **Same-edge set/clear and r0.** Same-edge set/clear of reg 9 → pend[9] stays 1. iss_dest=0 never raises hazard. A B result to dest 0 is popped with rf_we=0.
